// File: rtl/wb_result_stage.sv
// Write-back result stage: selects among five result sources, aligns and
// extends load data, waits for late memory responses and handles flushes.
module wb_result_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned SRC_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic             i_flush,
    input  logic [SRC_W-1:0] i_result_src,
    input  logic             i_reg_write,
    input  logic [4:0]       i_rd_addr,
    input  logic [2:0]       i_funct3,
    input  logic [XLEN-1:0]  i_alu_result,
    input  logic [XLEN-1:0]  i_pc_plus4,
    input  logic [XLEN-1:0]  i_imm,
    input  logic [XLEN-1:0]  i_csr_rdata,
    input  logic [XLEN-1:0]  i_mem_rdata,
    input  logic             i_mem_rvalid,
    output logic             o_wb_we,
    output logic [4:0]       o_wb_rd,
    output logic [XLEN-1:0]  o_wb_data,
    output logic             o_load_pending,
    output logic [4:0]       o_load_rd,
    output logic             o_load_fault,
    output logic             o_illegal_src
);

    localparam int unsigned OFF_W = $clog2(XLEN / 8);

    localparam logic [SRC_W-1:0] SRC_ALU = SRC_W'(0);
    localparam logic [SRC_W-1:0] SRC_MEM = SRC_W'(1);
    localparam logic [SRC_W-1:0] SRC_PC4 = SRC_W'(2);
    localparam logic [SRC_W-1:0] SRC_IMM = SRC_W'(3);
    localparam logic [SRC_W-1:0] SRC_CSR = SRC_W'(4);
    localparam logic [SRC_W-1:0] SRC_LIM = SRC_W'(5);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        DRAIN    = 2'd2
    } state_t;

    state_t           r_state;
    logic [4:0]       r_rd;
    logic [2:0]       r_funct3;
    logic [OFF_W-1:0] r_off;
    logic             r_reg_write;

    logic [2:0]       w_f3;
    logic [OFF_W-1:0] w_off;
    logic [XLEN-1:0]  w_shift;
    logic [XLEN-1:0]  w_ld_data;
    logic             w_ld_fault;
    logic [XLEN-1:0]  w_src_data;
    logic             w_src_illegal;

    // Load alignment / extension and fault detection for the active load
    always_comb begin
        w_f3       = (r_state == WAIT_MEM) ? r_funct3 : i_funct3;
        w_off      = (r_state == WAIT_MEM) ? r_off : i_alu_result[OFF_W-1:0];
        w_shift    = i_mem_rdata >> {w_off, 3'b000};
        w_ld_data  = w_shift;
        w_ld_fault = 1'b0;
        case (w_f3)
            3'b000: w_ld_data = XLEN'($signed(w_shift[7:0]));
            3'b001: begin
                w_ld_data  = XLEN'($signed(w_shift[15:0]));
                w_ld_fault = w_off[0];
            end
            3'b010: begin
                w_ld_data  = XLEN'($signed(w_shift[31:0]));
                w_ld_fault = (w_off[1:0] != 2'b00);
            end
            3'b011: begin
                w_ld_data  = w_shift;
                w_ld_fault = (XLEN == 32) || (w_off != '0);
            end
            3'b100: w_ld_data = XLEN'(w_shift[7:0]);
            3'b101: begin
                w_ld_data  = XLEN'(w_shift[15:0]);
                w_ld_fault = w_off[0];
            end
            3'b110: begin
                w_ld_data  = XLEN'(w_shift[31:0]);
                w_ld_fault = (XLEN == 32) || (w_off[1:0] != 2'b00);
            end
            default: w_ld_fault = 1'b1;
        endcase
    end

    // Non-load result source select
    always_comb begin
        w_src_data    = '0;
        w_src_illegal = 1'b0;
        case (i_result_src)
            SRC_ALU: w_src_data = i_alu_result;
            SRC_PC4: w_src_data = i_pc_plus4;
            SRC_IMM: w_src_data = i_imm;
            SRC_CSR: w_src_data = i_csr_rdata;
            default: w_src_illegal = (i_result_src >= SRC_LIM);
        endcase
    end

    assign o_in_ready = (r_state == IDLE);

    // State machine with registered write-back and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_rd           <= '0;
            r_funct3       <= '0;
            r_off          <= '0;
            r_reg_write    <= 1'b0;
            o_wb_we        <= 1'b0;
            o_wb_rd        <= '0;
            o_wb_data      <= '0;
            o_load_pending <= 1'b0;
            o_load_rd      <= '0;
            o_load_fault   <= 1'b0;
            o_illegal_src  <= 1'b0;
        end else begin
            o_wb_we       <= 1'b0;
            o_load_fault  <= 1'b0;
            o_illegal_src <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_in_valid && !i_flush) begin
                        if (i_result_src == SRC_MEM) begin
                            if (i_mem_rvalid) begin
                                o_wb_rd      <= i_rd_addr;
                                o_wb_data    <= w_ld_data;
                                o_wb_we      <= i_reg_write && (i_rd_addr != 5'd0) && !w_ld_fault;
                                o_load_fault <= w_ld_fault;
                            end else begin
                                r_state        <= WAIT_MEM;
                                r_rd           <= i_rd_addr;
                                r_funct3       <= i_funct3;
                                r_off          <= i_alu_result[OFF_W-1:0];
                                r_reg_write    <= i_reg_write;
                                o_load_pending <= 1'b1;
                                o_load_rd      <= i_rd_addr;
                            end
                        end else begin
                            o_wb_rd       <= i_rd_addr;
                            o_wb_data     <= w_src_data;
                            o_wb_we       <= i_reg_write && (i_rd_addr != 5'd0) && !w_src_illegal;
                            o_illegal_src <= w_src_illegal;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (i_flush) begin
                        r_state        <= i_mem_rvalid ? IDLE : DRAIN;
                        o_load_pending <= 1'b0;
                    end else if (i_mem_rvalid) begin
                        r_state        <= IDLE;
                        o_load_pending <= 1'b0;
                        o_wb_rd        <= r_rd;
                        o_wb_data      <= w_ld_data;
                        o_wb_we        <= r_reg_write && (r_rd != 5'd0) && !w_ld_fault;
                        o_load_fault   <= w_ld_fault;
                    end
                end
                DRAIN: begin
                    if (i_mem_rvalid) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/wb_result_stage.md
# wb_result_stage

Registered write-back stage for the RISC-V core. It generalises the 2-bit ALU/MEM/PC4 result-source selection to a 3-bit, five-source encoding. It adds load-data alignment and sign extension, waits for late memory responses, and handles flushes. It sits between the MEM stage and the register-file write port, and exposes a pending-load indication to the hazard unit.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values 32 and 64.
- SRC_W, 3, width of result_src. Codes: 0 ALU, 1 MEM, 2 PC4, 3 IMM, 4 CSR. Codes 0–2 keep their existing values.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  MEM stage presents an instruction
- in_ready  out  1  stage can accept an instruction
- flush  in  1  kill the instruction being accepted or in flight
- result_src  in  SRC_W  result source code
- reg_write  in  1  instruction writes rd
- rd_addr  in  5  destination register
- funct3  in  3  load type, used only when result_src=MEM
- alu_result  in  XLEN  ALU output; its low bits give the load byte offset
- pc_plus4  in  XLEN  link value
- imm  in  XLEN  U-type immediate
- csr_rdata  in  XLEN  CSR read data
- mem_rdata  in  XLEN  data-memory read word
- mem_rvalid  in  1  mem_rdata valid this cycle
- wb_we  out  1  register-file write enable, one-cycle pulse
- wb_rd  out  5  write address
- wb_data  out  XLEN  write data
- load_pending  out  1  load accepted, response not yet delivered
- load_rd  out  5  rd of the pending load
- load_fault  out  1  one-cycle pulse: misaligned or unsupported load
- illegal_src  out  1  one-cycle pulse: result_src code ≥5

## Operation
States:
- IDLE
  - in_ready=1.
  - An instruction is accepted when in_valid && !flush.
  - A non-MEM source is written back on the next cycle.
  - For a MEM source, if mem_rvalid is high in the same cycle, the load is written back next cycle. Otherwise go to WAIT_MEM and latch rd, funct3, offset and reg_write.
  - mem_rvalid while in IDLE with no accepted load is ignored.
- WAIT_MEM
  - in_ready=0, load_pending=1.
  - mem_rvalid && !flush: write back next cycle, go to IDLE.
  - flush with no mem_rvalid: go to DRAIN.
  - flush with mem_rvalid in the same cycle: discard the data, go to IDLE.
- DRAIN
  - in_ready=0, load_pending=0.
  - The next mem_rvalid is discarded; go to IDLE.

Source select:
- ALU → alu_result; PC4 → pc_plus4; IMM → imm; CSR → csr_rdata; MEM → extracted load data.

Load extraction:
- Offset = alu_result[log2(XLEN/8)-1:0].
- funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Signed loads sign-extend to XLEN; unsigned loads zero-extend.
- XLEN=64 adds 011 LD and 110 LWU.
- Misaligned accesses: halfword with offset[0]=1; word with offset[1:0]≠0; doubleword with offset≠0.
- Faults are misaligned accesses, funct3 111, and 011/110 when XLEN=32. A fault pulses load_fault in the write-back cycle with wb_we=0. The response is still awaited and consumed.

Write gating:
- wb_we = reg_write && rd≠0 && !fault && legal src.
- wb_rd and wb_data update on every write-back cycle, even when wb_we=0.

## Timing
- Reset values: state IDLE, wb_we=0, wb_rd=0, wb_data=0, load_pending=0, load_rd=0, load_fault=0, illegal_src=0. in_ready=1 after reset.
- Reset asserted mid-operation returns the stage to IDLE immediately and drops the pending load.
- Non-load accepted at cycle N → wb_we at N+1.
- Load with mem_rvalid at cycle M (M≥N) → wb_we at M+1.
- in_ready is combinational from state.
- load_pending and load_rd are registered and valid in the cycle after acceptance.
- flush has priority over in_valid and over mem_rvalid in the same cycle.
- illegal_src and load_fault pulse in the same cycle that wb_we would have asserted.
- Throughput is 1 instruction per cycle for non-loads and for loads with same-cycle responses.

## Test plan
- ALU op, rd=5, alu_result=0x1234, accepted at cycle 0 → wb_we=1, wb_rd=5, wb_data=0x00001234 at cycle 1. Repeat with src PC4, IMM and CSR; each returns its own input.
- LB, offset 3, mem_rdata=0x80FF_0000, response 2 cycles late → load_pending=1 and load_rd=rd until the response; in_ready=0. The cycle after mem_rvalid: wb_data=0xFFFF_FF80, wb_we=1.
- LHU, offset 2, mem_rdata=0xBEEF_1234, same-cycle response → wb_data=0x0000_BEEF one cycle later. LH at offset 1 → load_fault=1, wb_we=0.
- Load accepted, flush in WAIT_MEM, mem_rvalid 3 cycles later → no wb_we, DRAIN consumes the response, in_ready=1 the cycle after.
- rd=0 write, and result_src=5 → wb_we stays 0. illegal_src pulses exactly once, for the result_src=5 case.
- XLEN=64: LWU at offset 4 with mem_rdata=0x8765_4321_0000_0000 → wb_data=0x0000_0000_8765_4321. Assert rst_n low during WAIT_MEM → all outputs return to reset values.
